count_extender: RTL and testbench
=================================

Name: count_extender

Overview:
- Sits directly downstream of the 4-bit up/down counter and consumes its Count and UpOrDown.
- Detects 4-bit wrap-around and keeps an epoch register that extends Count to an EXT_W-bit position value.
- Flags illegal jumps between consecutive Count samples (not ±1 or hold), so software and display stages see a monotonic wide position and a fault indication.

Parameters:
EXT_W, 12, width of ext_count; epoch width is EXT_W-4 (legal range 5..32)

Ports:
Clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
Count  input  4  counter value from upstream counter
UpOrDown  input  1  direction from the counter's control (1 = down, 0 = up), same cycle as Count's driver
err_clr  input  1  single-cycle clear of fault; re-baselines tracking
ext_count  output  EXT_W  {epoch, Count} extended position, registered
valid  output  1  ext_count is meaningful
wrap_up  output  1  one-cycle pulse: 15->0 transition seen
wrap_down  output  1  one-cycle pulse: 0->15 transition seen
step_err  output  1  sticky: illegal Count jump detected
dir_err  output  1  sticky direction-mismatch flag; only with COUNT_EXT_DIR_CHECK_EN, else tied 0

Behaviour:
- Reset values:
  - ext_count=0, valid=0, wrap_up=0, wrap_down=0, step_err=0, dir_err=0.
  - Internal prev=0, epoch=0, state=INIT.
- FSM states are INIT, TRACK and FAULT.
- INIT (first cycle after reset or err_clr):
  - prev<=Count, epoch<=0, ext_count<={0,Count}, valid<=1.
  - Go to TRACK.
- TRACK, each cycle, with delta=(Count-prev) mod 16:
  - delta=0: hold, no pulses.
  - delta=1: legal up step. If prev==15, epoch<=epoch+1 and wrap_up<=1.
  - delta=15: legal down step. If prev==0, epoch<=epoch-1 and wrap_down<=1.
  - Other delta: step_err<=1, go to FAULT. epoch, ext_count and prev frozen at the last legal values; valid<=0.
  - On legal steps: prev<=Count, ext_count<={next epoch, Count}.
- Latency: ext_count and pulses are registered, 1 cycle after Count changes.
- Epoch arithmetic is modulo 2^(EXT_W-4); wrap of the epoch itself is silent (ext_count wraps 2^EXT_W-1 <-> 0).
- FAULT:
  - Outputs frozen, valid=0, step_err held.
  - err_clr=1 -> INIT next cycle, which clears step_err and dir_err.
  - Count changes are ignored while in FAULT.
- err_clr in TRACK: clears sticky flags and goes to INIT; epoch is reset to 0.
- Simultaneous err_clr and illegal step in TRACK: err_clr wins (INIT, no error recorded).
- Upstream counter reset mid-run (Count jumps to 0 from a value other than 1 or 15): treated as an illegal step -> FAULT. If the jump is from 1 or 15, it is indistinguishable from a legal step and is tracked normally.
- reset has priority over everything; it is synchronous only.

Optional Feature:
- Macro: COUNT_EXT_DIR_CHECK_EN
- When defined:
  - UpOrDown is registered (dir_q).
  - In TRACK, a legal delta=1 with dir_q=1, or delta=15 with dir_q=0, sets sticky dir_err.
  - Tracking continues (no FAULT); dir_err is cleared by err_clr or reset.
- When undefined: dir_err is constant 0 and UpOrDown is unused.

Test Plan:
- Reset, Count held 0 with UpOrDown=0 for 40 cycles, Count incrementing from 0 -> ext_count tracks 0..39 one cycle late; wrap_up pulses after 15->0 and 31->32 (2 pulses); valid=1 from the 2nd cycle after reset.
- Count counting up to ext_count=20 (0x014), then down 25 steps -> wrap_down pulses at 16->15 only (prev 0 -> 15, epoch 1->0) and at 0->-1; final ext_count=0xFFB (epoch 0xFF, Count 0xB).
- Count jumps 7 -> 3 -> step_err=1 and valid=0 the next cycle; ext_count frozen at 7 while Count keeps changing; err_clr with Count=9 -> INIT, ext_count=0x009, step_err=0, valid=1.
- Assert err_clr in the same cycle as an illegal jump 5 -> 12 -> no step_err; ext_count={0,12}.
- Epoch saturate-wrap check with EXT_W=5, counting up through 31->32 -> ext_count wraps to 0, wrap_up=1, no error.
- With COUNT_EXT_DIR_CHECK_EN: UpOrDown=1 but Count steps 4->5 -> dir_err=1, ext_count=5, tracking continues. Without the macro, dir_err stays 0.

Source files
------------

// File: rtl/count_extender.sv
// Extends a 4-bit up/down count to an EXT_W-bit position using an epoch register and flags illegal jumps.
// Optional direction cross-check against UpOrDown when COUNT_EXT_DIR_CHECK_EN is defined.
module count_extender #(
    parameter int EXT_W = 12
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [3:0]       Count,
    input  logic             UpOrDown,
    input  logic             err_clr,
    output logic [EXT_W-1:0] ext_count,
    output logic             valid,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             step_err,
    output logic             dir_err
);

    localparam int EPOCH_W = EXT_W - 4;
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1'b1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         prev_q, prev_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [EXT_W-1:0]   ext_q, ext_d;
    logic               valid_q, valid_d;
    logic               wrap_up_q, wrap_up_d;
    logic               wrap_down_q, wrap_down_d;
    logic               step_err_q, step_err_d;
    logic [3:0]         delta_s;
    logic               flag_clr_s;
    logic               step_up_s;
    logic               step_dn_s;

    assign delta_s = Count - prev_q;

    // Next-state and output decode for the tracking FSM
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        epoch_d     = epoch_q;
        ext_d       = ext_q;
        valid_d     = valid_q;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
        step_err_d  = step_err_q;
        flag_clr_s  = 1'b0;
        step_up_s   = 1'b0;
        step_dn_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                prev_d     = Count;
                epoch_d    = {EPOCH_W{1'b0}};
                ext_d      = {{EPOCH_W{1'b0}}, Count};
                valid_d    = 1'b1;
                step_err_d = 1'b0;
                flag_clr_s = 1'b1;
                state_d    = ST_TRACK;
            end
            ST_TRACK: begin
                if (err_clr) begin
                    // err_clr outranks any step seen in the same cycle
                    epoch_d    = {EPOCH_W{1'b0}};
                    step_err_d = 1'b0;
                    flag_clr_s = 1'b1;
                    state_d    = ST_INIT;
                end else begin
                    case (delta_s)
                        4'd0: begin
                            prev_d = prev_q;
                        end
                        4'd1: begin
                            step_up_s = 1'b1;
                            wrap_up_d = (prev_q == 4'd15);
                            epoch_d   = (prev_q == 4'd15) ? (epoch_q + EPOCH_ONE) : epoch_q;
                            prev_d    = Count;
                            ext_d     = {epoch_d, Count};
                        end
                        4'd15: begin
                            step_dn_s   = 1'b1;
                            wrap_down_d = (prev_q == 4'd0);
                            epoch_d     = (prev_q == 4'd0) ? (epoch_q - EPOCH_ONE) : epoch_q;
                            prev_d      = Count;
                            ext_d       = {epoch_d, Count};
                        end
                        default: begin
                            step_err_d = 1'b1;
                            valid_d    = 1'b0;
                            state_d    = ST_FAULT;
                        end
                    endcase
                end
            end
            ST_FAULT: begin
                if (err_clr) begin
                    step_err_d = 1'b0;
                    flag_clr_s = 1'b1;
                    state_d    = ST_INIT;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            prev_q      <= 4'd0;
            epoch_q     <= {EPOCH_W{1'b0}};
            ext_q       <= {EXT_W{1'b0}};
            valid_q     <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            epoch_q     <= epoch_d;
            ext_q       <= ext_d;
            valid_q     <= valid_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            step_err_q  <= step_err_d;
        end
    end

    assign ext_count = ext_q;
    assign valid     = valid_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign step_err  = step_err_q;

`ifdef COUNT_EXT_DIR_CHECK_EN
    logic dir_q;
    logic dir_err_q, dir_err_d;

    // Direction is that of the previous cycle, which produced the current Count
    always_comb begin
        dir_err_d = dir_err_q;
        if (flag_clr_s) begin
            dir_err_d = 1'b0;
        end else if ((step_up_s && dir_q) || (step_dn_s && !dir_q)) begin
            dir_err_d = 1'b1;
        end else begin
            dir_err_d = dir_err_q;
        end
    end

    // Direction sample and sticky mismatch flag
    always_ff @(posedge Clk) begin
        if (reset) begin
            dir_q     <= 1'b0;
            dir_err_q <= 1'b0;
        end else begin
            dir_q     <= UpOrDown;
            dir_err_q <= dir_err_d;
        end
    end

    assign dir_err = dir_err_q;
`else
    logic dir_unused_s;
    assign dir_unused_s = ^{UpOrDown, step_up_s, step_dn_s};
    assign dir_err      = 1'b0;
`endif

endmodule

// File: tb/tb_count_extender.sv
// Randomised bench for count_extender: a position-based reference model checks two instances (EXT_W 12 and 5) every cycle.
module tb_count_extender;

`ifdef COUNT_EXT_DIR_CHECK_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  cnt;
    logic        ud;
    logic        clr;

    logic [11:0] a_ext;
    logic        a_valid, a_wu, a_wd, a_se, a_de;
    logic [4:0]  b_ext;
    logic        b_valid, b_wu, b_wd, b_se, b_de;

    int tests;
    int fails;
    int wu_seen;
    int wd_seen;

    count_extender #(.EXT_W(12)) dut_a (
        .Clk(clk), .reset(rst), .Count(cnt), .UpOrDown(ud), .err_clr(clr),
        .ext_count(a_ext), .valid(a_valid), .wrap_up(a_wu), .wrap_down(a_wd),
        .step_err(a_se), .dir_err(a_de)
    );

    count_extender #(.EXT_W(5)) dut_b (
        .Clk(clk), .reset(rst), .Count(cnt), .UpOrDown(ud), .err_clr(clr),
        .ext_count(b_ext), .valid(b_valid), .wrap_up(b_wu), .wrap_down(b_wd),
        .step_err(b_se), .dir_err(b_de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unbounded position that moves by +-1 on each legal step
    localparam int M_INIT  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;
    int         m_mode;
    int         m_pos;
    logic [3:0] m_last;
    logic       m_valid, m_wu, m_wd, m_se, m_de, m_dirp, m_live;

    initial m_live = 1'b0;

    always @(posedge clk) begin
        m_wu   <= 1'b0;
        m_wd   <= 1'b0;
        m_dirp <= ud;
        if (rst) begin
            m_mode  <= M_INIT;
            m_pos   <= 0;
            m_last  <= 4'd0;
            m_valid <= 1'b0;
            m_se    <= 1'b0;
            m_de    <= 1'b0;
            m_dirp  <= 1'b0;
            m_live  <= 1'b1;
        end else if (m_mode == M_INIT) begin
            m_pos   <= int'(cnt);
            m_last  <= cnt;
            m_valid <= 1'b1;
            m_se    <= 1'b0;
            m_de    <= 1'b0;
            m_mode  <= M_TRACK;
        end else if (clr) begin
            m_se   <= 1'b0;
            m_de   <= 1'b0;
            m_mode <= M_INIT;
        end else if (m_mode == M_TRACK) begin
            if (cnt == m_last) begin
                m_last <= cnt;
            end else if (cnt == 4'(m_last + 4'd1)) begin
                m_pos  <= m_pos + 1;
                m_last <= cnt;
                m_wu   <= (cnt == 4'd0);
                if (DIR_EN && m_dirp) m_de <= 1'b1;
            end else if (cnt == 4'(m_last - 4'd1)) begin
                m_pos  <= m_pos - 1;
                m_last <= cnt;
                m_wd   <= (cnt == 4'd15);
                if (DIR_EN && !m_dirp) m_de <= 1'b1;
            end else begin
                m_se    <= 1'b1;
                m_valid <= 1'b0;
                m_mode  <= M_FAULT;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_live) begin
            logic [31:0] pos_u;
            pos_u = m_pos;
            check("ext12", 32'(a_ext), 32'(pos_u[11:0]));
            check("valid12", 32'(a_valid), 32'(m_valid));
            check("wrap_up12", 32'(a_wu), 32'(m_wu));
            check("wrap_down12", 32'(a_wd), 32'(m_wd));
            check("step_err12", 32'(a_se), 32'(m_se));
            check("dir_err12", 32'(a_de), 32'(m_de));
            check("ext5", 32'(b_ext), 32'(pos_u[4:0]));
            check("valid5", 32'(b_valid), 32'(m_valid));
            check("wrap_up5", 32'(b_wu), 32'(m_wu));
            check("wrap_down5", 32'(b_wd), 32'(m_wd));
            check("step_err5", 32'(b_se), 32'(m_se));
            check("dir_err5", 32'(b_de), 32'(m_de));
            wu_seen += int'(a_wu);
            wd_seen += int'(a_wd);
        end
    end

    // Apply one set of inputs and return just after the edge that consumed them
    task automatic tick(input logic [3:0] c, input logic d, input logic cl, input logic r);
        @(negedge clk);
        cnt = c;
        ud  = d;
        clr = cl;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wu0, wd0, r;
        logic [3:0] cur;
        tests = 0; fails = 0; wu_seen = 0; wd_seen = 0;
        rst = 1'b1; cnt = 4'd0; ud = 1'b0; clr = 1'b0;

        // Reset, then count up 0..39
        repeat (3) tick(4'd0, 1'b0, 1'b0, 1'b1);
        check("rst_ext", 32'(a_ext), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_step_err", 32'(a_se), 32'd0);
        wu0 = wu_seen;
        for (int i = 0; i < 40; i++) begin
            tick(4'(i), 1'b0, 1'b0, 1'b0);
            if (i == 0) check("first_valid", 32'(a_valid), 32'd1);
            if (i == 32) begin
                check("w5_ext_wrap", 32'(b_ext), 32'd0);
                check("w5_wrap_up", 32'(b_wu), 32'd1);
                check("w5_no_err", 32'(b_se), 32'd0);
            end
        end
        check("up_ext39", 32'(a_ext), 32'd39);
        check("up_ext5", 32'(b_ext), 32'd7);
        check("up_wraps", 32'(wu_seen - wu0), 32'd2);

        // Up to 20 then down 25 steps through zero
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 20; i++) tick(4'(i), 1'b0, 1'b0, 1'b0);
        check("ext20", 32'(a_ext), 32'h014);
        wd0 = wd_seen;
        for (int k = 1; k <= 25; k++) tick(4'(20 - k), 1'b1, 1'b0, 1'b0);
        check("down_ext", 32'(a_ext), 32'hFFB);
        check("down_ext5", 32'(b_ext), 32'd27);
        check("down_wraps", 32'(wd_seen - wd0), 32'd2);

        // Illegal jump, frozen outputs, recovery by err_clr
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 7; i++) tick(4'(i), 1'b0, 1'b0, 1'b0);
        tick(4'd3, 1'b0, 1'b0, 1'b0);
        check("jump_err", 32'(a_se), 32'd1);
        check("jump_valid", 32'(a_valid), 32'd0);
        check("jump_ext", 32'(a_ext), 32'd7);
        tick(4'd10, 1'b0, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0, 1'b0);
        check("frozen_ext", 32'(a_ext), 32'd7);
        tick(4'd9, 1'b0, 1'b1, 1'b0);
        tick(4'd9, 1'b0, 1'b0, 1'b0);
        check("clr_ext", 32'(a_ext), 32'h009);
        check("clr_err", 32'(a_se), 32'd0);
        check("clr_valid", 32'(a_valid), 32'd1);

        // err_clr together with an illegal jump
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 5; i++) tick(4'(i), 1'b0, 1'b0, 1'b0);
        tick(4'd12, 1'b0, 1'b1, 1'b0);
        check("race_err", 32'(a_se), 32'd0);
        tick(4'd12, 1'b0, 1'b0, 1'b0);
        check("race_ext", 32'(a_ext), 32'd12);
        check("race_err2", 32'(a_se), 32'd0);

        // Direction mismatch: told down, counted up
        tick(4'd4, 1'b1, 1'b0, 1'b1);
        tick(4'd4, 1'b1, 1'b0, 1'b0);
        tick(4'd5, 1'b1, 1'b0, 1'b0);
        check("dir_ext", 32'(a_ext), 32'd5);
        check("dir_flag", 32'(a_de), 32'(DIR_EN));
        check("dir_valid", 32'(a_valid), 32'd1);

        // Randomised traffic
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        cur = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                cur = cur + 4'd1;
                tick(cur, ($urandom_range(0, 5) == 0), 1'b0, 1'b0);
            end else if (r < 70) begin
                cur = cur - 4'd1;
                tick(cur, ($urandom_range(0, 5) != 0), 1'b0, 1'b0);
            end else if (r < 86) begin
                tick(cur, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else if (r < 93) begin
                cur = cur + 4'($urandom_range(2, 14));
                tick(cur, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else if (r < 98) begin
                cur = 4'($urandom_range(0, 15));
                tick(cur, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end else begin
                tick(cur, 1'b0, 1'b0, 1'b1);
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
